// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, slot ids and the legality helper.
package alu_pkg;

  localparam int unsigned ALU_FUNC_W = 4;

  localparam logic [ALU_FUNC_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_FUNC_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_FUNC_W-1:0] ALU_XOR  = 4'b0010;
  localparam logic [ALU_FUNC_W-1:0] ALU_XNOR = 4'b0011;
  localparam logic [ALU_FUNC_W-1:0] ALU_ADD  = 4'b0100;
  localparam logic [ALU_FUNC_W-1:0] ALU_SUB  = 4'b1100;
  localparam logic [ALU_FUNC_W-1:0] ALU_SLT  = 4'b1101;
  localparam logic [ALU_FUNC_W-1:0] ALU_SLTU = 4'b0110;

  localparam logic SLOT0 = 1'b0;
  localparam logic SLOT1 = 1'b1;

  // True for the eight defined function codes.
  function automatic logic alu_func_legal(input logic [ALU_FUNC_W-1:0] func);
    logic ok;
    case (func)
      ALU_AND, ALU_OR, ALU_XOR, ALU_XNOR,
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_share_arb_alu.sv
// Existing combinational integer ALU; undefined codes produce zero.
module ALU
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FUNC_W = 4
) (
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic [FUNC_W-1:0] func,
  output logic [WIDTH-1:0]  aluout
);

  // Function decode; add/sub wrap, compares yield zero-extended 0/1.
  always_comb begin
    aluout = '0;
    case (func)
      FUNC_W'(ALU_AND):  aluout = in1 & in2;
      FUNC_W'(ALU_OR):   aluout = in1 | in2;
      FUNC_W'(ALU_XOR):  aluout = in1 ^ in2;
      FUNC_W'(ALU_XNOR): aluout = ~(in1 ^ in2);
      FUNC_W'(ALU_ADD):  aluout = in1 + in2;
      FUNC_W'(ALU_SUB):  aluout = in1 - in2;
      FUNC_W'(ALU_SLT):  aluout = WIDTH'($signed(in1) < $signed(in2));
      FUNC_W'(ALU_SLTU): aluout = WIDTH'(in1 < in2);
      default:           aluout = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter for two issue slots sharing one ALU, with result register.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FUNC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [WIDTH-1:0]  in1_0,
  input  logic [WIDTH-1:0]  in2_0,
  input  logic [WIDTH-1:0]  in1_1,
  input  logic [WIDTH-1:0]  in2_1,
  input  logic [FUNC_W-1:0] func_0,
  input  logic [FUNC_W-1:0] func_1,
  input  logic              stall,
  output logic              gnt0,
  output logic              gnt1,
  output logic              res_valid,
  output logic              res_id,
  output logic [WIDTH-1:0]  res_data,
  output logic              res_err
);

  logic              prio;
  logic              grant;
  logic              sel;
  logic [WIDTH-1:0]  in1_sel;
  logic [WIDTH-1:0]  in2_sel;
  logic [FUNC_W-1:0] func_sel;
  logic [WIDTH-1:0]  alu_out;
  logic              func_ok;

  // Grant: nothing during reset or stall, otherwise lone requester or prio slot wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && !stall) begin
      gnt0 = req0 && (!req1 || (prio == SLOT0));
      gnt1 = req1 && (!req0 || (prio == SLOT1));
    end
  end

  // Operand mux steered by the winning slot.
  always_comb begin
    grant    = gnt0 | gnt1;
    sel      = gnt1 ? SLOT1 : SLOT0;
    in1_sel  = (sel == SLOT1) ? in1_1  : in1_0;
    in2_sel  = (sel == SLOT1) ? in2_1  : in2_0;
    func_sel = (sel == SLOT1) ? func_1 : func_0;
    func_ok  = alu_func_legal(ALU_FUNC_W'(func_sel));
  end

  ALU #(
    .WIDTH  (WIDTH),
    .FUNC_W (FUNC_W)
  ) u_alu (
    .in1    (in1_sel),
    .in2    (in2_sel),
    .func   (func_sel),
    .aluout (alu_out)
  );

  // Priority and result registers; stall freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio      <= SLOT0;
      res_valid <= 1'b0;
      res_id    <= SLOT0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else if (!stall) begin
      if (grant) begin
        prio      <= ~sel;
        res_valid <= 1'b1;
        res_id    <= sel;
        res_data  <= func_ok ? alu_out : '0;
        res_err   <= ~func_ok;
      end else begin
        res_valid <= 1'b0;
        res_err   <= 1'b0;
      end
    end
  end

endmodule
